tcam_search: RTL and testbench
==============================

# tcam_search

Read-side search engine for the TCAM entry RAM. It accepts a search key over a valid/ready handshake and sweeps every RAM address through the RAM's synchronous read port. Each returned entry is compared as a ternary (value, care-mask) pair, and the block reports hit, the lowest matching address and the total match count over a second valid/ready handshake. It sits between the lookup client and the entry RAM. The write side of the RAM stays with the table-update logic.

## Interface
- KEY_WIDTH, 8, search key width; multiple of 8.
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH entries.

- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  key offered.
- key_ready  out  1  block can accept a key; high only in IDLE.
- key  in  KEY_WIDTH  search key, sampled on accept.
- rd_addr  out  ADDR_WIDTH  RAM read address (registered).
- rd_data  in  2*KEY_WIDTH  RAM read data, valid one cycle after rd_addr; [2*KEY_WIDTH-1:KEY_WIDTH] is the care mask, [KEY_WIDTH-1:0] is the value.
- result_valid  out  1  result presented.
- result_ready  in  1  client accepts result.
- hit  out  1  at least one entry matched.
- match_addr  out  ADDR_WIDTH  lowest matching address; 0 when no hit.
- match_count  out  ADDR_WIDTH+1  number of matching entries, 0..DEPTH.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - key_ready=1.
  - When key_valid is high, latch key, clear the hit/addr/count accumulators, set rd_addr=0 and go to SCAN.
- SCAN:
  - key_ready=0.
  - rd_addr increments by 1 each cycle until it reaches DEPTH-1, then holds.
  - An internal compare-valid pipeline bit tracks which cycles carry real rd_data, so the first SCAN cycle's rd_data is ignored.
  - Match rule: ((rd_data[KEY_WIDTH-1:0] ^ key_q) & rd_data[2*KEY_WIDTH-1:KEY_WIDTH]) == 0. An all-zero mask matches any key.
  - On each valid compare that matches: increment match_count. If hit is still 0, set hit=1 and match_addr to the address of that entry, which is rd_addr delayed by one cycle.
  - Later matches do not overwrite match_addr (lowest address wins).
  - After the compare of entry DEPTH-1 is registered, go to DONE.
- DONE:
  - result_valid=1.
  - hit, match_addr and match_count stay stable until result_ready is high on a clock edge; then go to IDLE.
  - key_ready stays 0 in DONE, so a key can be accepted no earlier than the cycle after the result handshake.
- Full sweep always: no early exit on first hit.
- match_count is ADDR_WIDTH+1 bits, so DEPTH matches does not wrap.
- The key input is ignored outside IDLE; changing it mid-scan has no effect.
- key_valid with no key accepted (outside IDLE) is held off by key_ready=0; the client must keep offering the key.

## Timing
- Reset values: key_ready=1, result_valid=0, hit=0, match_addr=0, match_count=0, rd_addr=0, state=IDLE.
- The rst_n assertion takes effect immediately (asynchronous).
- Reset mid-SCAN or in DONE: the current search is discarded and the block returns to IDLE with the values above. The client must re-issue the key.
- Let E0 be the edge on which the key is accepted:
  - rd_addr = k after edge E(k+1) for k = 0..DEPTH-1.
  - rd_data = mem[k] after edge E(k+2).
  - result_valid rises after edge E(DEPTH+2).
  - Latency is DEPTH+2 cycles: 18 at the default parameters.
- With result_ready held high, result_valid lasts exactly one cycle. key_ready then returns one cycle later.
- Back-to-back searches: minimum spacing is DEPTH+4 cycles from one key accept to the next.
- RAM contents must not change during a scan; coherence with concurrent writes is the client's responsibility.

## Test plan
- Single exact match: write mem[3]={8'hFF,8'hFE}, all other entries {8'hFF,8'h00}; key=8'hFE. Required: hit=1, match_addr=3, match_count=1, result_valid high 18 cycles after accept.
- Priority and count: mem[5]={8'hF0,8'hA0} and mem[9]={8'hFF,8'hA5}, rest non-matching; key=8'hA5. Required: hit=1, match_addr=5, match_count=2.
- No match: mem filled {8'hFF,8'h11}; key=8'h22. Required: hit=0, match_addr=0, match_count=0.
- All wildcards: every mask 8'h00; any key. Required: hit=1, match_addr=0, match_count=16 (no wrap).
- Handshake backpressure: hold result_ready=0 for 5 cycles after result_valid; toggle key_valid and key throughout. Required: outputs stable, key_ready=0, no second accept; after result_ready=1, go to IDLE and accept the next key.
- Reset mid-scan: assert rst_n=0 at rd_addr=7. Required: all outputs immediately at reset values; a new search after release gives a correct result.

Source files
------------

// File: rtl/tcam_search.sv
// tcam_search
//   Read-side search engine for the TCAM entry RAM. A key is accepted over a
//   valid/ready handshake. Every RAM address is then swept through the RAM's
//   synchronous read port. Each returned entry is a ternary {care-mask, value}
//   pair. The block reports hit, the lowest matching address and the number of
//   matches over a second valid/ready handshake.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   key_valid/key_ready, key    search key handshake (ready only in IDLE)
//   rd_addr                     registered RAM read address
//   rd_data                     RAM read data, one cycle after rd_addr
//                               {mask[2K-1:K], value[K-1:0]}
//   result_valid/result_ready   result handshake
//   hit, match_addr, match_count  search result, held until accepted
module tcam_search #(
  parameter int KEY_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [KEY_WIDTH-1:0]    key,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [2*KEY_WIDTH-1:0]  rd_data,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    hit,
  output logic [ADDR_WIDTH-1:0]   match_addr,
  output logic [ADDR_WIDTH:0]     match_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t                  state_r;
  state_t                  state_s;
  logic                    accept_s;
  logic                    match_s;
  logic [KEY_WIDTH-1:0]    key_q;
  // issue_r: rd_addr currently presents a real address to the RAM.
  // cv_r: rd_data this cycle belongs to a real address (addr_q_r).
  logic                    issue_r;
  logic                    cv_r;
  logic [ADDR_WIDTH-1:0]   addr_q_r;

  // Ternary compare: only bits with a set care-mask bit must agree.
  function automatic logic ternary_match(input logic [2*KEY_WIDTH-1:0] entry,
                                         input logic [KEY_WIDTH-1:0]   k);
    return (((entry[KEY_WIDTH-1:0] ^ k) & entry[2*KEY_WIDTH-1:KEY_WIDTH])
            == {KEY_WIDTH{1'b0}});
  endfunction

  assign match_s = ternary_match(rd_data, key_q);

  // Next-state decode and key-accept strobe.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_valid) begin
          state_s  = SCAN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      SCAN: begin
        // Leave once the compare of the last entry is being registered.
        if (cv_r && (addr_q_r == LAST_ADDR)) begin
          state_s = DONE;
        end else begin
          state_s = SCAN;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with registered handshake outputs decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      key_ready    <= 1'b1;
      result_valid <= 1'b0;
    end else begin
      state_r      <= state_s;
      key_ready    <= (state_s == IDLE);
      result_valid <= (state_s == DONE);
    end
  end

  // Address sweep, compare-valid pipeline and result accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= {KEY_WIDTH{1'b0}};
      rd_addr     <= {ADDR_WIDTH{1'b0}};
      issue_r     <= 1'b0;
      cv_r        <= 1'b0;
      addr_q_r    <= {ADDR_WIDTH{1'b0}};
      hit         <= 1'b0;
      match_addr  <= {ADDR_WIDTH{1'b0}};
      match_count <= {(ADDR_WIDTH+1){1'b0}};
    end else if (accept_s) begin
      key_q       <= key;
      rd_addr     <= {ADDR_WIDTH{1'b0}};
      issue_r     <= 1'b0;
      cv_r        <= 1'b0;
      addr_q_r    <= {ADDR_WIDTH{1'b0}};
      hit         <= 1'b0;
      match_addr  <= {ADDR_WIDTH{1'b0}};
      match_count <= {(ADDR_WIDTH+1){1'b0}};
    end else if (state_r == SCAN) begin
      cv_r     <= issue_r;
      addr_q_r <= rd_addr;
      // The first SCAN cycle only starts issuing (address 0 is held one
      // extra cycle); issuing stops after the last address has been sent.
      if (!issue_r && !cv_r) begin
        issue_r <= 1'b1;
      end else if (issue_r && (rd_addr == LAST_ADDR)) begin
        issue_r <= 1'b0;
      end
      if (issue_r && (rd_addr != LAST_ADDR)) begin
        rd_addr <= rd_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
      if (cv_r && match_s) begin
        match_count <= match_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
        // First match seen is the lowest address since the sweep ascends.
        if (!hit) begin
          hit        <= 1'b1;
          match_addr <= addr_q_r;
        end
      end
    end else begin
      issue_r <= 1'b0;
      cv_r    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tcam_search.sv
module tb_tcam_search;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [7:0]  key;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        result_valid;
  logic        result_ready;
  logic        hit;
  logic [3:0]  match_addr;
  logic [4:0]  match_count;

  logic [15:0] mem [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] def;
    logic [3:0]  ia;
    logic [15:0] va;
    logic [3:0]  ib;
    logic [15:0] vb;
    logic [7:0]  key;
    logic        exp_hit;
    logic [3:0]  exp_addr;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t vecs [6];

  tcam_search #(.KEY_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key          (key),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .hit          (hit),
    .match_addr   (match_addr),
    .match_count  (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model: data one cycle after address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 16; i++) mem[i] = v.def;
    mem[v.ia] = v.va;
    mem[v.ib] = v.vb;
  endtask

  // Offer a key and let it be accepted on the next edge (E0).
  task automatic start_key(input logic [7:0] k);
    int w;
    w = 0;
    while (!key_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("key_ready_before_accept", int'(key_ready), 1);
    key_valid = 1'b1;
    key       = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key       = ~k;   // must not influence the running search
  endtask

  task automatic run_search(input vec_t v, input int hold);
    int lat;
    lat = 0;
    load(v);
    start_key(v.key);
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 18);
    chk("hit", int'(hit), int'(v.exp_hit));
    chk("match_addr", int'(match_addr), int'(v.exp_addr));
    chk("match_count", int'(match_count), int'(v.exp_cnt));
    for (int c = 0; c < hold; c++) begin
      key_valid = c[0];
      key       = 8'($urandom);
      @(posedge clk); #1;
      chk("bp_result_valid", int'(result_valid), 1);
      chk("bp_key_ready", int'(key_ready), 0);
      chk("bp_hit", int'(hit), int'(v.exp_hit));
      chk("bp_match_addr", int'(match_addr), int'(v.exp_addr));
      chk("bp_match_count", int'(match_count), int'(v.exp_cnt));
    end
    key_valid    = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("post_hs_result_valid", int'(result_valid), 0);
    chk("post_hs_key_ready", int'(key_ready), 1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_key_ready"}, int'(key_ready), 1);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_hit"}, int'(hit), 0);
    chk({tag, "_match_addr"}, int'(match_addr), 0);
    chk({tag, "_match_count"}, int'(match_count), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
  endtask

  initial begin
    int w;
    //          def       ia     va       ib     vb       key    hit   addr   cnt
    vecs[0] = '{16'hFF00, 4'd3,  16'hFFFE, 4'd3,  16'hFFFE, 8'hFE, 1'b1, 4'd3,  5'd1};
    vecs[1] = '{16'hFF00, 4'd5,  16'hF0A0, 4'd9,  16'hFFA5, 8'hA5, 1'b1, 4'd5,  5'd2};
    vecs[2] = '{16'hFF11, 4'd0,  16'hFF11, 4'd0,  16'hFF11, 8'h22, 1'b0, 4'd0,  5'd0};
    vecs[3] = '{16'h005A, 4'd0,  16'h005A, 4'd0,  16'h005A, 8'h77, 1'b1, 4'd0,  5'd16};
    vecs[4] = '{16'hFF00, 4'd15, 16'hFF3C, 4'd0,  16'h0F0C, 8'h3C, 1'b1, 4'd0,  5'd2};
    vecs[5] = '{16'hFF00, 4'd15, 16'hFF3C, 4'd15, 16'hFF3C, 8'h3C, 1'b1, 4'd15, 5'd1};

    rst_n        = 1'b0;
    key_valid    = 1'b0;
    key          = 8'h00;
    result_ready = 1'b0;
    rd_data      = 16'h0000;
    load(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table; the priority vector also exercises result backpressure.
    for (int n = 0; n < 6; n++) begin
      run_search(vecs[n], (n == 1) ? 5 : 0);
    end

    // Reset in the middle of a scan.
    load(vecs[0]);
    start_key(vecs[0].key);
    w = 0;
    while (rd_addr != 4'd7 && w < 40) begin
      @(posedge clk); #1; w++;
    end
    chk("reached_rd_addr_7", int'(rd_addr), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("midscan_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_search(vecs[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
